// File: rtl/sem_pkg.sv
// Shared definitions for the pedestrian-crossing controller: states, lamp
// patterns and default phase durations.
package sem_pkg;

  typedef enum logic [2:0] {
    ALLRED_A,
    CARS_GREEN,
    CARS_AMBER,
    ALLRED_B,
    WALK,
    BLINK,
    NIGHT_M
  } sem_state_t;

  // Lamp vectors are ordered {Rcars, Gcars, Rpedes, Gpedes}
  localparam logic [3:0] LAMP_ALLRED = 4'b1010;
  localparam logic [3:0] LAMP_GREEN  = 4'b0110;
  localparam logic [3:0] LAMP_AMBER  = 4'b1110;
  localparam logic [3:0] LAMP_WALK   = 4'b1001;

  localparam int unsigned DEF_T_GREEN  = 20;
  localparam int unsigned DEF_T_AMBER  = 5;
  localparam int unsigned DEF_T_ALLRED = 2;
  localparam int unsigned DEF_T_WALK   = 15;
  localparam int unsigned DEF_T_BLINK  = 5;

  localparam int unsigned SEC_W = 6;

  function automatic logic [3:0] lamp_pattern(sem_state_t st, logic phase);
    case (st)
      CARS_GREEN: lamp_pattern = LAMP_GREEN;
      CARS_AMBER: lamp_pattern = LAMP_AMBER;
      WALK:       lamp_pattern = LAMP_WALK;
      BLINK:      lamp_pattern = {3'b100, ~phase};
      NIGHT_M:    lamp_pattern = {~phase, ~phase, 2'b00};
      default:    lamp_pattern = LAMP_ALLRED;
    endcase
  endfunction

endpackage

// File: rtl/sem_timer.sv
// Loadable down-counter that saturates at zero; advances only on tick.
module sem_timer #(
  parameter int unsigned     W       = 6,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         one
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= value;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == W'(1));

endmodule

// File: rtl/sem_ctrl.sv
// Traffic/pedestrian crossing controller with request latch, blinking
// pedestrian phase and night (blinking amber) mode. All outputs registered.
module sem_ctrl
  import sem_pkg::*;
#(
  parameter int unsigned T_GREEN  = DEF_T_GREEN,
  parameter int unsigned T_AMBER  = DEF_T_AMBER,
  parameter int unsigned T_ALLRED = DEF_T_ALLRED,
  parameter int unsigned T_WALK   = DEF_T_WALK,
  parameter int unsigned T_BLINK  = DEF_T_BLINK
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK_ENA,
  input  logic             PED_REQ,
  input  logic             NIGHT,
  output logic             Rcars,
  output logic             Gcars,
  output logic             Rpedes,
  output logic             Gpedes,
  output logic             WAIT_LED,
  output logic [SEC_W-1:0] SEC_LEFT
);

  if (T_GREEN < 1 || T_GREEN > 63 || T_AMBER < 1 || T_AMBER > 63 ||
      T_ALLRED < 1 || T_ALLRED > 63 || T_WALK < 1 || T_WALK > 63 ||
      T_BLINK < 1 || T_BLINK > 63) begin : g_param_check
    $error("sem_ctrl: all durations must lie in 1..63");
  end

  sem_state_t       state, state_nxt;
  logic             flag, flag_nxt;
  logic             phase, phase_nxt;
  logic             entering;
  logic [3:0]       lamps;
  logic [SEC_W-1:0] load_val;
  logic             cnt_zero, cnt_one;

  function automatic logic [SEC_W-1:0] duration(sem_state_t st);
    case (st)
      ALLRED_A, ALLRED_B: duration = SEC_W'(T_ALLRED);
      CARS_GREEN:         duration = SEC_W'(T_GREEN);
      CARS_AMBER:         duration = SEC_W'(T_AMBER);
      WALK:               duration = SEC_W'(T_WALK);
      BLINK:              duration = SEC_W'(T_BLINK);
      default:            duration = '0;
    endcase
  endfunction

  sem_timer #(
    .W       (SEC_W),
    .RST_VAL (SEC_W'(T_ALLRED))
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .load  (entering),
    .value (load_val),
    .tick  (CLK_ENA),
    .count (SEC_LEFT),
    .zero  (cnt_zero),
    .one   (cnt_one)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ALLRED_A:   if (CLK_ENA && cnt_one) state_nxt = NIGHT ? CARS_AMBER : CARS_GREEN;
      CARS_GREEN: if (NIGHT || (cnt_zero && flag)) state_nxt = CARS_AMBER;
      CARS_AMBER: if (CLK_ENA && cnt_one) state_nxt = NIGHT ? NIGHT_M : ALLRED_B;
      ALLRED_B:   if (CLK_ENA && cnt_one) state_nxt = WALK;
      WALK:       if (CLK_ENA && cnt_one) state_nxt = BLINK;
      BLINK:      if (CLK_ENA && cnt_one) state_nxt = ALLRED_A;
      NIGHT_M:    if (!NIGHT) state_nxt = ALLRED_A;
      default:    state_nxt = ALLRED_A;
    endcase

    entering = (state_nxt != state);
    load_val = duration(state_nxt);

    // Clearing on WALK entry wins over a press in the same cycle
    flag_nxt = flag;
    if (PED_REQ && (state != WALK) && (state != BLINK)) flag_nxt = 1'b1;
    if (entering && (state_nxt == WALK)) flag_nxt = 1'b0;

    phase_nxt = phase;
    if (entering) phase_nxt = 1'b0;
    else if (CLK_ENA && ((state == BLINK) || (state == NIGHT_M))) phase_nxt = ~phase;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ALLRED_A;
      flag  <= 1'b0;
      phase <= 1'b0;
      lamps <= LAMP_ALLRED;
    end else begin
      state <= state_nxt;
      flag  <= flag_nxt;
      phase <= phase_nxt;
      lamps <= lamp_pattern(state_nxt, phase_nxt);
    end
  end

  assign {Rcars, Gcars, Rpedes, Gpedes} = lamps;
  assign WAIT_LED = flag;

endmodule

// File: tb/tb_sem_ctrl.sv
// Randomized scoreboard bench for sem_ctrl against a cycle-level reference
// model of the crossing rules.
module tb_sem_ctrl;

  localparam int unsigned TG = 20, TA = 5, TR = 2, TW = 15, TB = 5;

  logic       CLK = 1'b0;
  logic       RST, CLK_ENA, PED_REQ, NIGHT;
  logic       Rcars, Gcars, Rpedes, Gpedes, WAIT_LED;
  logic [5:0] SEC_LEFT;

  sem_ctrl #(
    .T_GREEN  (TG),
    .T_AMBER  (TA),
    .T_ALLRED (TR),
    .T_WALK   (TW),
    .T_BLINK  (TB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CLK_ENA  (CLK_ENA),
    .PED_REQ  (PED_REQ),
    .NIGHT    (NIGHT),
    .Rcars    (Rcars),
    .Gcars    (Gcars),
    .Rpedes   (Rpedes),
    .Gpedes   (Gpedes),
    .WAIT_LED (WAIT_LED),
    .SEC_LEFT (SEC_LEFT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] lamps;
    logic       wait_led;
    logic [5:0] sec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  bit   armed  = 1'b0;

  // Reference model: which phase of the crossing cycle, ticks left, pending
  // pedestrian request, and the blink level
  typedef enum int {M_CLEAR1, M_GREEN, M_AMBER, M_CLEAR2, M_WALK, M_FLASH, M_NIGHT} mphase_t;
  mphase_t     mp;
  int unsigned left;
  bit          req;
  bit          blk;

  function automatic int unsigned dwell(mphase_t p);
    case (p)
      M_CLEAR1, M_CLEAR2: return TR;
      M_GREEN:            return TG;
      M_AMBER:            return TA;
      M_WALK:             return TW;
      M_FLASH:            return TB;
      default:            return 0;
    endcase
  endfunction

  function automatic void model_step(bit rst, bit ena, bit ped, bit night);
    mphase_t nxt;
    bit      done;
    if (rst) begin
      mp = M_CLEAR1; left = TR; req = 1'b0; blk = 1'b0;
      return;
    end
    nxt  = mp;
    done = ena && (left == 1);
    case (mp)
      M_CLEAR1: if (done) nxt = night ? M_AMBER : M_GREEN;
      M_GREEN:  if (night || (left == 0 && req)) nxt = M_AMBER;
      M_AMBER:  if (done) nxt = night ? M_NIGHT : M_CLEAR2;
      M_CLEAR2: if (done) nxt = M_WALK;
      M_WALK:   if (done) nxt = M_FLASH;
      M_FLASH:  if (done) nxt = M_CLEAR1;
      default:  if (!night) nxt = M_CLEAR1;
    endcase
    if (ped && mp != M_WALK && mp != M_FLASH) req = 1'b1;
    if (nxt != mp) begin
      if (nxt == M_WALK) req = 1'b0;
      left = dwell(nxt);
      blk  = 1'b0;
    end else begin
      if (ena && left > 0) left = left - 1;
      if (ena && (mp == M_FLASH || mp == M_NIGHT)) blk = !blk;
    end
    mp = nxt;
  endfunction

  function automatic exp_t expected();
    exp_t e;
    case (mp)
      M_GREEN: e.lamps = 4'b0110;
      M_AMBER: e.lamps = 4'b1110;
      M_WALK:  e.lamps = 4'b1001;
      M_FLASH: e.lamps = {3'b100, !blk};
      M_NIGHT: e.lamps = {!blk, !blk, 2'b00};
      default: e.lamps = 4'b1010;
    endcase
    e.wait_led = req;
    e.sec      = 6'(left);
    return e;
  endfunction

  task automatic check(string name, int act, int req_v);
    checks++;
    if (act != req_v) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  task automatic step(bit rst, bit ena, bit ped, bit night);
    @(negedge CLK);
    RST = rst; CLK_ENA = ena; PED_REQ = ped; NIGHT = night;
    model_step(rst, ena, ped, night);
    sb.push_back(expected());
    armed = 1'b1;
  endtask

  task automatic run_seg(int unsigned n, int unsigned ena_den, int unsigned ped_den,
                         int unsigned night_den, int unsigned rst_den);
    bit ped = 1'b0, night = 1'b0, rst, ena;
    for (int unsigned i = 0; i < n; i++) begin
      ena = ($urandom_range(0, ena_den - 1) == 0);
      if (ped_den != 0 && $urandom_range(0, ped_den - 1) == 0) ped = !ped;
      if (night_den != 0 && $urandom_range(0, night_den - 1) == 0) night = !night;
      rst = (rst_den != 0) && ($urandom_range(0, rst_den - 1) == 0);
      step(rst, ena, ped, night);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("lamps", int'({Rcars, Gcars, Rpedes, Gpedes}), int'(e.lamps));
        check("wait_led", int'(WAIT_LED), int'(e.wait_led));
        check("sec_left", int'(SEC_LEFT), int'(e.sec));
      end else if (armed) begin
        check("scoreboard underrun", 0, 1);
      end
    end
  end

  initial begin
    RST = 1'b1; CLK_ENA = 1'b0; PED_REQ = 1'b0; NIGHT = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    run_seg(1500, 3, 40, 0, 0);
    run_seg(3000, 2, 20, 150, 700);
    run_seg(1500, 1, 8, 60, 0);
    run_seg(1000, 4, 30, 400, 300);
    @(posedge CLK);
    #2;
    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
